// File: rtl/codec_map_dec_output_pp_ram.sv
// Ping-pong frame RAM: pWPORT_N interleaved write ports, pRATIO-wide reads, two committed-frame banks.
// Optional port-conflict detection compiled in with `define CODEC_MAP_DEC_OUTPUT_PP_RAM_CONFLICT_EN.
module codec_map_dec_output_pp_ram #(
    parameter int pWDAT_W  = 1,
    parameter int pWPORT_N = 2,
    parameter int pRATIO   = 1,
    parameter int pADDR_W  = 8,
    parameter int pWPIPE   = 0
) (
    input  logic                                iclk,
    input  logic                                ireset,
    input  logic                                iclkena,
    input  logic                                iwrite,
    input  logic [pWPORT_N-1:0][pADDR_W-1:0]    iwaddr,
    input  logic [pWPORT_N-1:0][pWDAT_W-1:0]    iwdata,
    input  logic                                iwfull,
    output logic                                owfull,
    input  logic                                iread,
    input  logic [pADDR_W-$clog2(pRATIO)-1:0]   iraddr,
    input  logic                                irempty,
    output logic                                orempty,
    output logic [pRATIO*pWDAT_W-1:0]           ordata,
    output logic                                orval,
    output logic                                oerr
);

    localparam int LOG_N = $clog2(pWPORT_N);
    localparam int SUB_W = pADDR_W - LOG_N;
    localparam int DEPTH = 1 << SUB_W;

    logic                               s_write;
    logic                               s_full;
    logic [pWPORT_N-1:0][pADDR_W-1:0]   s_addr;
    logic [pWPORT_N-1:0][pWDAT_W-1:0]   s_data;

    logic       wr_ok;
    logic       commit;
    logic       rel;
    logic       rd_ok;
    logic [1:0] used;
    logic [1:0] used_nx;
    logic       wptr;
    logic       rptr;

    generate
        if (pWPIPE != 0) begin : g_pipe
            logic                               p_write;
            logic                               p_full;
            logic [pWPORT_N-1:0][pADDR_W-1:0]   p_addr;
            logic [pWPORT_N-1:0][pWDAT_W-1:0]   p_data;

            always_ff @(posedge iclk or negedge ireset) begin
                if (!ireset) begin
                    p_write <= 1'b0;
                    p_full  <= 1'b0;
                    p_addr  <= '0;
                    p_data  <= '0;
                end else if (iclkena) begin
                    p_write <= iwrite;
                    p_full  <= iwfull;
                    p_addr  <= iwaddr;
                    p_data  <= iwdata;
                end
            end

            assign s_write = p_write;
            assign s_full  = p_full;
            assign s_addr  = p_addr;
            assign s_data  = p_data;
        end else begin : g_nopipe
            assign s_write = iwrite;
            assign s_full  = iwfull;
            assign s_addr  = iwaddr;
            assign s_data  = iwdata;
        end
    endgenerate

    // Full-gating is applied after the pipe stage so a write queued behind a commit never lands in a full bank.
    assign wr_ok  = s_write & ~owfull;
    assign commit = s_full & ~owfull;
    assign rel    = irempty & (used != 2'd0);
    assign rd_ok  = iread & ~orempty;

    always_comb begin
        used_nx = used;
        if (commit && !rel)
            used_nx = used + 2'd1;
        else if (rel && !commit)
            used_nx = used - 2'd1;
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            used    <= 2'd0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            owfull  <= 1'b0;
            orempty <= 1'b1;
        end else if (iclkena) begin
            used    <= used_nx;
            owfull  <= (used_nx == 2'd2);
            orempty <= (used_nx == 2'd0);
            if (commit)
                wptr <= ~wptr;
            if (rel)
                rptr <= ~rptr;
        end
    end

    // Per sub-bank write mux; the lowest-indexed port targeting a sub-bank wins.
    logic [pWPORT_N-1:0]                we;
    logic [pWPORT_N-1:0][SUB_W-1:0]     wsub_addr;
    logic [pWPORT_N-1:0][pWDAT_W-1:0]   wsub_data;

    always_comb begin
        we        = '0;
        wsub_addr = '0;
        wsub_data = '0;
        for (int unsigned s = 0; s < pWPORT_N; s++) begin
            for (int unsigned p = 0; p < pWPORT_N; p++) begin
                if (!we[s] && s_addr[p][LOG_N-1:0] == LOG_N'(s)) begin
                    we[s]        = 1'b1;
                    wsub_addr[s] = s_addr[p][pADDR_W-1:LOG_N];
                    wsub_data[s] = s_data[p];
                end
            end
        end
    end

`ifdef CODEC_MAP_DEC_OUTPUT_PP_RAM_CONFLICT_EN
    logic                conflict;
    logic [pWPORT_N-1:0] seen;
    logic                err_r;

    always_comb begin
        conflict = 1'b0;
        seen     = '0;
        for (int unsigned p = 0; p < pWPORT_N; p++) begin
            if (seen[s_addr[p][LOG_N-1:0]])
                conflict = 1'b1;
            seen[s_addr[p][LOG_N-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset)
            err_r <= 1'b0;
        else if (iclkena)
            err_r <= wr_ok & conflict;
    end

    assign oerr = err_r;
`else
    assign oerr = 1'b0;
`endif

    // Read side: the pRATIO words of one read always fall in distinct sub-banks.
    logic [pWPORT_N-1:0][SUB_W-1:0]     rsub_addr;
    logic [pWPORT_N-1:0][pWDAT_W-1:0]   rword;
    logic [pRATIO-1:0][LOG_N-1:0]       rsel;
    logic [pADDR_W-1:0]                 word_addr;
    logic [pRATIO*pWDAT_W-1:0]          rdata_nx;

    always_comb begin
        rsub_addr = '0;
        rsel      = '0;
        word_addr = '0;
        for (int unsigned j = 0; j < pRATIO; j++) begin
            word_addr = pADDR_W'(iraddr) * pADDR_W'(pRATIO) + pADDR_W'(j);
            rsel[j]   = word_addr[LOG_N-1:0];
            rsub_addr[word_addr[LOG_N-1:0]] = word_addr[pADDR_W-1:LOG_N];
        end
    end

    always_comb begin
        rdata_nx = '0;
        for (int unsigned j = 0; j < pRATIO; j++)
            rdata_nx[j*pWDAT_W +: pWDAT_W] = rword[rsel[j]];
    end

    generate
        for (genvar s = 0; s < pWPORT_N; s++) begin : g_sub
            logic [pWDAT_W-1:0] mem [2][DEPTH];

            always_ff @(posedge iclk) begin
                if (iclkena && wr_ok && we[s])
                    mem[wptr][wsub_addr[s]] <= wsub_data[s];
            end

            assign rword[s] = mem[rptr][rsub_addr[s]];
        end
    endgenerate

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            orval  <= 1'b0;
            ordata <= '0;
        end else if (iclkena) begin
            orval <= rd_ok;
            if (rd_ok)
                ordata <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_codec_map_dec_output_pp_ram.sv
// Scoreboard bench for codec_map_dec_output_pp_ram: a 2-port/ratio-1 instance and a 4-port/ratio-4 pipelined instance.
module tb_codec_map_dec_output_pp_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clkena;

    // instance A: 2 ports, ratio 1, no write pipe
    logic             rst_a;
    logic             a_write, a_wfull, a_owfull, a_read, a_rempty, a_orempty, a_rval, a_err;
    logic [1:0][7:0]  a_waddr;
    logic [1:0][7:0]  a_wdata;
    logic [7:0]       a_raddr;
    logic [7:0]       a_rdata;

    // instance B: 4 ports, ratio 4, write pipe
    logic             rst_b;
    logic             b_write, b_wfull, b_owfull, b_read, b_rempty, b_orempty, b_rval, b_err;
    logic [3:0][7:0]  b_waddr;
    logic [3:0][7:0]  b_wdata;
    logic [5:0]       b_raddr;
    logic [31:0]      b_rdata;

    codec_map_dec_output_pp_ram #(
        .pWDAT_W(8), .pWPORT_N(2), .pRATIO(1), .pADDR_W(8), .pWPIPE(0)
    ) u_a (
        .iclk(clk), .ireset(rst_a), .iclkena(clkena),
        .iwrite(a_write), .iwaddr(a_waddr), .iwdata(a_wdata),
        .iwfull(a_wfull), .owfull(a_owfull),
        .iread(a_read), .iraddr(a_raddr), .irempty(a_rempty), .orempty(a_orempty),
        .ordata(a_rdata), .orval(a_rval), .oerr(a_err)
    );

    codec_map_dec_output_pp_ram #(
        .pWDAT_W(8), .pWPORT_N(4), .pRATIO(4), .pADDR_W(8), .pWPIPE(1)
    ) u_b (
        .iclk(clk), .ireset(rst_b), .iclkena(clkena),
        .iwrite(b_write), .iwaddr(b_waddr), .iwdata(b_wdata),
        .iwfull(b_wfull), .owfull(b_owfull),
        .iread(b_read), .iraddr(b_raddr), .irempty(b_rempty), .orempty(b_orempty),
        .ordata(b_rdata), .orval(b_rval), .oerr(b_err)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rval === 1'b1) begin
            if (a_q.size() == 0) check("a_q_occupancy", a_q.size(), 1);
            else check("a_rdata", a_rdata, a_q.pop_front());
        end
        if (b_rval === 1'b1) begin
            if (b_q.size() == 0) check("b_q_occupancy", b_q.size(), 1);
            else check("b_rdata", b_rdata, b_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write_frame(input logic [7:0] d, input logic rel_last);
        for (int i = 0; i < 128; i++) begin
            a_write    = 1'b1;
            a_waddr[0] = 8'(2*i);
            a_waddr[1] = 8'(2*i + 1);
            a_wdata[0] = 8'(2*i) + d;
            a_wdata[1] = 8'(2*i + 1) + d;
            a_wfull    = (i == 127);
            a_rempty   = rel_last && (i == 127);
            tick();
        end
        a_write  = 1'b0;
        a_wfull  = 1'b0;
        a_rempty = 1'b0;
    endtask

    task automatic a_read_frame(input logic [7:0] d);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            a_read  = 1'b1;
            a_raddr = 8'(i);
            v       = 8'(i) + d;
            a_q.push_back({24'd0, v});
            tick();
        end
        a_read = 1'b0;
        tick();
        tick();
    endtask

    task automatic a_release();
        a_rempty = 1'b1;
        tick();
        a_rempty = 1'b0;
    endtask

    task automatic b_write_words(input logic [7:0] d, input int n, input logic full_last);
        for (int i = 0; i < n; i++) begin
            b_write = 1'b1;
            for (int p = 0; p < 4; p++) begin
                b_waddr[p] = 8'(4*i + p);
                b_wdata[p] = 8'(4*i + p) + d;
            end
            b_wfull = full_last && (i == n - 1);
            tick();
        end
        b_write = 1'b0;
        b_wfull = 1'b0;
    endtask

    function automatic logic [31:0] b_exp(input logic [7:0] d, input int idx);
        logic [31:0] r;
        logic [7:0]  v;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            v = 8'(4*idx + j) + d;
            r[j*8 +: 8] = v;
        end
        return r;
    endfunction

    task automatic b_read_word(input int idx, input logic [31:0] exp);
        b_read  = 1'b1;
        b_raddr = 6'(idx);
        b_q.push_back(exp);
        tick();
        check("b_orval_latency", b_rval, 1);
        b_read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        clkena = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0;
        a_write = 0; a_wfull = 0; a_read = 0; a_rempty = 0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        b_write = 0; b_wfull = 0; b_read = 0; b_rempty = 0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        tick();
        tick();
        check("a_rst_orempty", a_orempty, 1);
        check("a_rst_owfull",  a_owfull,  0);
        check("a_rst_orval",   a_rval,    0);
        check("a_rst_ordata",  a_rdata,   0);
        check("a_rst_oerr",    a_err,     0);
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        // clock enable low: a commit strobe must not take effect
        clkena = 1'b0; a_write = 1'b1; a_wfull = 1'b1;
        tick();
        check("a_clkena_hold", a_orempty, 1);
        a_write = 1'b0; a_wfull = 1'b0; clkena = 1'b1;
        tick();

        // single frame write/read
        a_write_frame(8'h00, 1'b0);
        check("a_commit_orempty", a_orempty, 0);
        check("a_commit_owfull",  a_owfull,  0);
        check("a_noconf_oerr",    a_err,     0);
        a_read_frame(8'h00);
        a_release();
        check("a_release_orempty", a_orempty, 1);

        // both banks full: further writes ignored
        a_write_frame(8'h00, 1'b0);
        a_write_frame(8'h10, 1'b0);
        check("a_full_owfull", a_owfull, 1);
        a_write_frame(8'h55, 1'b0);
        check("a_full_owfull_hold",  a_owfull,  1);
        check("a_full_orempty",      a_orempty, 0);
        a_read_frame(8'h00);
        a_release();
        check("a_rel1_owfull",  a_owfull,  0);
        check("a_rel1_orempty", a_orempty, 0);
        a_read_frame(8'h10);
        a_release();
        check("a_rel2_orempty", a_orempty, 1);

        // commit and release in the same cycle with one frame held
        a_write_frame(8'h20, 1'b0);
        check("a_one_orempty", a_orempty, 0);
        a_write_frame(8'h30, 1'b1);
        check("a_swap_orempty", a_orempty, 0);
        check("a_swap_owfull",  a_owfull,  0);
        a_read_frame(8'h30);
        a_release();
        check("a_swap_rel_orempty", a_orempty, 1);

        // two ports hitting the same sub-bank
        a_write = 1'b1; a_wfull = 1'b1;
        a_waddr[0] = 8'd4; a_waddr[1] = 8'd4;
        a_wdata[0] = 8'h0A; a_wdata[1] = 8'h0B;
        tick();
        a_write = 1'b0; a_wfull = 1'b0;
`ifdef CODEC_MAP_DEC_OUTPUT_PP_RAM_CONFLICT_EN
        check("a_conf_oerr", a_err, 1);
`else
        check("a_conf_oerr", a_err, 0);
`endif
        tick();
        check("a_conf_oerr_pulse", a_err, 0);
`ifdef CODEC_MAP_DEC_OUTPUT_PP_RAM_CONFLICT_EN
        a_read = 1'b1; a_raddr = 8'd4;
        a_q.push_back(32'h0000000A);
        tick();
        a_read = 1'b0;
        tick();
        tick();
`endif
        a_release();

        // 4-port, ratio-4, pipelined instance
        b_write_words(8'h00, 64, 1'b1);
        tick();
        check("b_commit_orempty", b_orempty, 0);
        check("b_commit_oerr",    b_err,     0);
        b_read_word(5,  32'h17161514);
        b_read_word(0,  b_exp(8'h00, 0));
        b_read_word(63, b_exp(8'h00, 63));
        b_rempty = 1'b1;
        tick();
        b_rempty = 1'b0;
        check("b_release_orempty", b_orempty, 1);

        // reset mid-frame discards a committed frame and a partial one
        b_write_words(8'h00, 64, 1'b1);
        tick();
        b_read_word(5, 32'h17161514);
        b_write_words(8'h11, 10, 1'b0);
        b_write = 1'b1;
        rst_b = 1'b0;
        #2;
        check("b_rst_orempty", b_orempty, 1);
        check("b_rst_owfull",  b_owfull,  0);
        check("b_rst_orval",   b_rval,    0);
        check("b_rst_ordata",  b_rdata,   0);
        check("b_rst_oerr",    b_err,     0);
        b_write = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        b_write_words(8'h40, 64, 1'b1);
        tick();
        check("b_after_rst_orempty", b_orempty, 0);
        check("b_after_rst_owfull",  b_owfull,  0);
        b_read_word(0,  b_exp(8'h40, 0));
        b_read_word(5,  b_exp(8'h40, 5));
        b_read_word(63, b_exp(8'h40, 63));

        tick();
        check("a_q_left", a_q.size(), 0);
        check("b_q_left", b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_map_dec_output_pp_ram.md
CODEC_MAP_DEC_OUTPUT_PP_RAM -- requirements
Module: codec_map_dec_output_pp_ram

Interface
REQ-001 SHALL have parameter pWDAT_W, default 1: write word width per port.
REQ-002 SHALL have parameter pWPORT_N, default 2: concurrent write ports, 2 or 4 only.
REQ-003 SHALL have parameter pRATIO, default 1: read width = pRATIO*pWDAT_W, pRATIO in {1,2,4} and pRATIO <= pWPORT_N.
REQ-004 SHALL have parameter pADDR_W, default 8: word address width of one frame bank.
REQ-005 SHALL have parameter pWPIPE, default 0: 1 adds one write-path register stage.
REQ-006 SHALL have ports (name, direction, width, meaning):
- iclk  in  1  single clock.
- ireset  in  1  asynchronous, active-low reset.
- iclkena  in  1  clock enable; all state holds when low.
- iwrite  in  1  write strobe, all ports.
- iwaddr  in  pWPORT_N x pADDR_W  per-port word address.
- iwdata  in  pWPORT_N x pWDAT_W  per-port data.
- iwfull  in  1  last write of frame; commit write bank.
- owfull  out  1  both banks hold committed frames.
- iread  in  1  read strobe.
- iraddr  in  pADDR_W-log2(pRATIO)  read address in pRATIO-word units.
- irempty  in  1  frame fully read; release read bank.
- orempty  out  1  no committed frame.
- ordata  out  pRATIO*pWDAT_W  read data.
- orval  out  1  ordata valid strobe.
- oerr  out  1  write bank-conflict pulse.

Function
REQ-007 SHALL hold two frame banks (ping-pong), each split into pWPORT_N sub-banks selected by address bits [log2(pWPORT_N)-1:0].
REQ-008 SHALL route each write port by its own address low bits to its sub-bank of write bank wptr; sub-bank index = remaining high address bits.
REQ-009 SHALL ignore iwrite and iwfull while owfull=1.
REQ-010 SHALL keep counter used (0..2): iwfull alone -> used+1, wptr toggles; irempty alone (used>0) -> used-1, rptr toggles; both in same cycle -> used unchanged, both pointers toggle; irempty with used=0 ignored.
REQ-011 SHALL drive owfull = (used==2) and orempty = (used==0), registered.
REQ-012 SHALL write data presented together with iwfull into the bank being committed, before toggle.
REQ-013 SHALL, with pWPIPE=1, delay iwrite, addresses, data and iwfull by one cycle as a group, so commit order is preserved; write latency 1 (pWPIPE=0) or 2 (pWPIPE=1) cycles to RAM.
REQ-014 SHALL read bank rptr: ordata slice j (bits (j+1)*pWDAT_W-1 : j*pWDAT_W) = word at address iraddr*pRATIO+j.
REQ-015 SHALL register ordata with latency 1 cycle; orval = iread & !orempty delayed 1 cycle; ordata holds when orval=0.
REQ-016 SHALL not define read data for a word written to the read bank while it is being read (no read-during-write check).

Reset
REQ-017 SHALL on ireset=0, asynchronously: used=0, wptr=0, rptr=0, owfull=0, orempty=1, orval=0, ordata=0, oerr=0, pipeline valids=0; RAM contents not reset.
REQ-018 SHALL, on reset mid-frame, discard all committed and partial frames.

Configuration
REQ-019 SHALL compile conflict detection when macro CODEC_MAP_DEC_OUTPUT_PP_RAM_CONFLICT_EN is defined: if two or more ports target the same sub-bank in one accepted write, lowest port index wins, others dropped, oerr=1 for one cycle (registered).
REQ-020 SHALL, without the macro, tie oerr to 0 and leave conflicting-write results undefined.

Verification
REQ-021 SHALL cover: reset, pWPORT_N=2, pRATIO=1, write addresses 0..255 with data=addr (pairs even/odd), iwfull on last -> orempty 0 next cycle; read 0..255 -> ordata=addr, 1-cycle latency.
REQ-022 SHALL cover: pWPORT_N=4, pRATIO=4, write words 0..255 = addr, commit; read iraddr=5 -> ordata = {23,22,21,20}.
REQ-023 SHALL cover: commit two frames without irempty -> owfull=1; further iwrite/iwfull ignored, frame 1 data intact; irempty -> owfull=0, reads return frame 2.
REQ-024 SHALL cover: iwfull and irempty same cycle with used=1 -> used stays 1, wptr and rptr both toggle, orempty stays 0.
REQ-025 SHALL cover: macro defined, ports 0 and 1 both write addr 4 (data 0xA, 0xB) -> oerr pulses once, readback 0xA; macro undefined -> oerr stays 0.
REQ-026 SHALL cover: pWPIPE=1, ireset low mid-frame after 10 writes -> all outputs at reset values, orempty=1, next frame written and read correctly.
